// File: rtl/ksa_pipe_param.sv
// ksa_pipe_param
// Fully pipelined Kogge-Stone adder/subtractor, parametrised by operand width.
// Every prefix level is a separate clocked stage, so a new operand pair can be
// accepted on every enabled cycle. Results leave LEVELS+2 enabled edges after
// the operands are sampled.
//
// Parameters
//   WIDTH          operand width in bits (2..64, need not be a power of two)
// Ports
//   GCLK_Pad       clock, rising edge
//   rstn_Pad       synchronous active-low reset (wins over en_Pad)
//   en_Pad         pipeline advance enable; 0 freezes every register
//   in_valid_Pad   a/b/cin/sub qualify this cycle
//   sub_Pad        0: a+b+cin, 1: a+~b+1 (cin_Pad ignored)
//   a_Pad, b_Pad   operands
//   cin_Pad        carry-in for add mode
//   sum_Pad        result (keeps last valid value across bubbles)
//   cout_Pad       carry out of the MSB (sub mode: 1 = no borrow)
//   ovf_Pad        two's-complement overflow
//   out_valid_Pad  sum/cout/ovf carry a new result
module ksa_pipe_param #(
   parameter int WIDTH = 4
) (
   input  logic             GCLK_Pad,
   input  logic             rstn_Pad,
   input  logic             en_Pad,
   input  logic             in_valid_Pad,
   input  logic             sub_Pad,
   input  logic [WIDTH-1:0] a_Pad,
   input  logic [WIDTH-1:0] b_Pad,
   input  logic             cin_Pad,
   output logic [WIDTH-1:0] sum_Pad,
   output logic             cout_Pad,
   output logic             ovf_Pad,
   output logic             out_valid_Pad
);

   // Derived; not meant to be overridden.
   localparam int LEVELS = $clog2(WIDTH);

   // Input capture stage
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             cin_r;
   logic             v0_r;

   // Prefix stages: index 0 holds generate/propagate, index k holds level k.
   // gg = group generate, gp = group propagate, p = original bit propagate.
   logic [WIDTH-1:0] gg_r [0:LEVELS];
   logic [WIDTH-1:0] gp_r [0:LEVELS];
   logic [WIDTH-1:0] p_r  [0:LEVELS];
   logic             c_r  [0:LEVELS];
   logic             v_r  [0:LEVELS];

   logic [WIDTH-1:0] g0_s;
   logic [WIDTH-1:0] p0_s;
   logic [WIDTH-1:0] gg_s [1:LEVELS];
   logic [WIDTH-1:0] gp_s [1:LEVELS];

   logic [WIDTH-1:0] sum_s;
   logic             cout_s;
   logic             ovf_s;

   // Operand capture: subtract is folded in as inverted B plus a forced carry-in.
   always_ff @(posedge GCLK_Pad) begin
      if (!rstn_Pad) begin
         a_r   <= '0;
         b_r   <= '0;
         cin_r <= 1'b0;
         v0_r  <= 1'b0;
      end else if (en_Pad) begin
         a_r   <= a_Pad;
         b_r   <= b_Pad ^ {WIDTH{sub_Pad}};
         cin_r <= sub_Pad | cin_Pad;
         v0_r  <= in_valid_Pad;
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         cin_r <= cin_r;
         v0_r  <= v0_r;
      end
   end

   // Bit generate/propagate; carry-in enters as part of bit 0's generate so
   // every later G[i] is the true carry out of bit i.
   always_comb begin
      p0_s    = a_r ^ b_r;
      g0_s    = a_r & b_r;
      g0_s[0] = (a_r[0] & b_r[0]) | (p0_s[0] & cin_r);
   end

   // First pipeline register after capture
   always_ff @(posedge GCLK_Pad) begin
      if (!rstn_Pad) begin
         gg_r[0] <= '0;
         gp_r[0] <= '0;
         p_r[0]  <= '0;
         c_r[0]  <= 1'b0;
         v_r[0]  <= 1'b0;
      end else if (en_Pad) begin
         gg_r[0] <= g0_s;
         gp_r[0] <= p0_s;
         p_r[0]  <= p0_s;
         c_r[0]  <= cin_r;
         v_r[0]  <= v0_r;
      end else begin
         gg_r[0] <= gg_r[0];
         gp_r[0] <= gp_r[0];
         p_r[0]  <= p_r[0];
         c_r[0]  <= c_r[0];
         v_r[0]  <= v_r[0];
      end
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int DIST = 1 << (k - 1);

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= DIST) begin : g_comb
            assign gg_s[k][i] = gg_r[k-1][i] | (gp_r[k-1][i] & gg_r[k-1][i-DIST]);
            assign gp_s[k][i] = gp_r[k-1][i] & gp_r[k-1][i-DIST];
         end else begin : g_pass
            // Partner lies below bit 0: combine with identity (G=0, P=1).
            assign gg_s[k][i] = gg_r[k-1][i];
            assign gp_s[k][i] = gp_r[k-1][i];
         end
      end

      // Prefix level k register; original p, carry-in and valid ride along
      always_ff @(posedge GCLK_Pad) begin
         if (!rstn_Pad) begin
            gg_r[k] <= '0;
            gp_r[k] <= '0;
            p_r[k]  <= '0;
            c_r[k]  <= 1'b0;
            v_r[k]  <= 1'b0;
         end else if (en_Pad) begin
            gg_r[k] <= gg_s[k];
            gp_r[k] <= gp_s[k];
            p_r[k]  <= p_r[k-1];
            c_r[k]  <= c_r[k-1];
            v_r[k]  <= v_r[k-1];
         end else begin
            gg_r[k] <= gg_r[k];
            gp_r[k] <= gp_r[k];
            p_r[k]  <= p_r[k];
            c_r[k]  <= c_r[k];
            v_r[k]  <= v_r[k];
         end
      end
   end

   // Sum uses the carry into each bit; ovf compares carry into and out of the MSB.
   assign sum_s  = p_r[LEVELS] ^ {gg_r[LEVELS][WIDTH-2:0], c_r[LEVELS]};
   assign cout_s = gg_r[LEVELS][WIDTH-1];
   assign ovf_s  = gg_r[LEVELS][WIDTH-2] ^ gg_r[LEVELS][WIDTH-1];

   // Output register: only a valid result replaces sum/cout/ovf
   always_ff @(posedge GCLK_Pad) begin
      if (!rstn_Pad) begin
         sum_Pad       <= '0;
         cout_Pad      <= 1'b0;
         ovf_Pad       <= 1'b0;
         out_valid_Pad <= 1'b0;
      end else if (en_Pad) begin
         out_valid_Pad <= v_r[LEVELS];
         if (v_r[LEVELS]) begin
            sum_Pad  <= sum_s;
            cout_Pad <= cout_s;
            ovf_Pad  <= ovf_s;
         end else begin
            sum_Pad  <= sum_Pad;
            cout_Pad <= cout_Pad;
            ovf_Pad  <= ovf_Pad;
         end
      end else begin
         sum_Pad       <= sum_Pad;
         cout_Pad      <= cout_Pad;
         ovf_Pad       <= ovf_Pad;
         out_valid_Pad <= out_valid_Pad;
      end
   end

endmodule

// File: tb/tb_ksa_pipe_param.sv
// Testbench for ksa_pipe_param: three instances (WIDTH 4, 16, 5) driven
// independently. Stimulus pushes expected results into per-instance queues;
// a monitor pops and compares whenever out_valid is seen after an enabled edge.
module tb_ksa_pipe_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int WD  [3] = '{4, 16, 5};
   localparam int LAT [3] = '{4, 6, 5};

   logic        rstn  [3];
   logic        en    [3];
   logic        iv    [3];
   logic        sub_i [3];
   logic        cin_i [3];
   logic [15:0] a_i   [3];
   logic [15:0] b_i   [3];
   logic [15:0] sum_o [3];
   logic        co_o  [3];
   logic        ov_o  [3];
   logic        vo_o  [3];

   logic [3:0]  s4;
   logic [15:0] s16;
   logic [4:0]  s5;
   assign sum_o[0] = {12'd0, s4};
   assign sum_o[1] = s16;
   assign sum_o[2] = {11'd0, s5};

   ksa_pipe_param #(.WIDTH(4)) dut4 (
      .GCLK_Pad(clk), .rstn_Pad(rstn[0]), .en_Pad(en[0]), .in_valid_Pad(iv[0]),
      .sub_Pad(sub_i[0]), .a_Pad(a_i[0][3:0]), .b_Pad(b_i[0][3:0]), .cin_Pad(cin_i[0]),
      .sum_Pad(s4), .cout_Pad(co_o[0]), .ovf_Pad(ov_o[0]), .out_valid_Pad(vo_o[0]));

   ksa_pipe_param #(.WIDTH(16)) dut16 (
      .GCLK_Pad(clk), .rstn_Pad(rstn[1]), .en_Pad(en[1]), .in_valid_Pad(iv[1]),
      .sub_Pad(sub_i[1]), .a_Pad(a_i[1]), .b_Pad(b_i[1]), .cin_Pad(cin_i[1]),
      .sum_Pad(s16), .cout_Pad(co_o[1]), .ovf_Pad(ov_o[1]), .out_valid_Pad(vo_o[1]));

   ksa_pipe_param #(.WIDTH(5)) dut5 (
      .GCLK_Pad(clk), .rstn_Pad(rstn[2]), .en_Pad(en[2]), .in_valid_Pad(iv[2]),
      .sub_Pad(sub_i[2]), .a_Pad(a_i[2][4:0]), .b_Pad(b_i[2][4:0]), .cin_Pad(cin_i[2]),
      .sum_Pad(s5), .cout_Pad(co_o[2]), .ovf_Pad(ov_o[2]), .out_valid_Pad(vo_o[2]));

   typedef struct {
      longint s;
      bit     co;
      bit     ov;
      int     due;
   } exp_t;

   exp_t sb [3][$];
   int   ecnt [3];
   int   n_cmp = 0;
   int   n_fail = 0;

   bit          rs [3];
   bit          es [3];
   logic [15:0] psum [3];
   logic        pco [3];
   logic        pov [3];
   logic        pvo [3];

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[w%0d] t=%0t: got %0h expected %0h", nm, WD[d], $time, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input int w, input longint a, input longint b, input bit c,
                                 input bit s, output longint sum, output bit co, output bit ov);
      longint m;
      longint sa;
      longint sbv;
      longint full;
      longint sres;
      m   = longint'(1) << w;
      sa  = (a >= m / 2) ? a - m : a;
      sbv = (b >= m / 2) ? b - m : b;
      if (s) begin
         full = a - b;
         co   = (a >= b);
         sres = sa - sbv;
      end else begin
         full = a + b + longint'(c);
         co   = (full >= m);
         sres = sa + sbv + longint'(c);
      end
      sum = full & (m - 1);
      ov  = (sres >= m / 2) || (sres < -(m / 2));
   endfunction

   // Drive one cycle of stimulus (called at a negedge) and record the expectation.
   task automatic drv(input int d, input bit v, input bit e, input longint a, input longint b,
                      input bit c, input bit s);
      exp_t x;
      iv[d]    = v;
      en[d]    = e;
      a_i[d]   = a[15:0];
      b_i[d]   = b[15:0];
      cin_i[d] = c;
      sub_i[d] = s;
      if (v && e && rstn[d]) begin
         model(WD[d], a, b, c, s, x.s, x.co, x.ov);
         x.due = ecnt[d] + 1 + LAT[d];
         sb[d].push_back(x);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int d, input int n);
      repeat (n) drv(d, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
   endtask

   // Monitor: count enabled edges, then check outputs 1 time unit after the edge.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         rs[d] = rstn[d];
         es[d] = en[d];
         if (rs[d] && es[d]) ecnt[d]++;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         if (!rs[d]) begin
            sb[d].delete();
            chk("reset_valid", d, 64'(vo_o[d]), 64'd0);
            chk("reset_sum", d, {47'd0, co_o[d], sum_o[d]}, 64'd0);
         end else if (!es[d]) begin
            chk("hold_sum", d, {46'd0, ov_o[d], co_o[d], sum_o[d]}, {46'd0, pov[d], pco[d], psum[d]});
            chk("hold_valid", d, 64'(vo_o[d]), 64'(pvo[d]));
         end else if (vo_o[d]) begin
            if (sb[d].size() == 0) begin
               chk("unexpected_valid", d, 64'd1, 64'd0);
            end else begin
               exp_t x;
               x = sb[d].pop_front();
               chk("sum", d, 64'(sum_o[d]), x.s);
               chk("cout", d, 64'(co_o[d]), 64'(x.co));
               chk("ovf", d, 64'(ov_o[d]), 64'(x.ov));
               chk("latency", d, 64'(ecnt[d]), 64'(x.due));
            end
         end else if (sb[d].size() > 0 && sb[d][0].due <= ecnt[d]) begin
            chk("missing_result", d, 64'd0, 64'd1);
            void'(sb[d].pop_front());
         end
         psum[d] = sum_o[d];
         pco[d]  = co_o[d];
         pov[d]  = ov_o[d];
         pvo[d]  = vo_o[d];
      end
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rstn[d] = 1'b0; en[d] = 1'b1; iv[d] = 1'b0; sub_i[d] = 1'b0;
         cin_i[d] = 1'b0; a_i[d] = 16'd0; b_i[d] = 16'd0; ecnt[d] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) rstn[d] = 1'b1;

      // Single add, result must be valid for exactly one cycle
      drv(0, 1'b1, 1'b1, 64'd2, 64'd3, 1'b0, 1'b0);
      idle(0, 8);
      // Signed overflow on add, then subtract with borrow
      drv(0, 1'b1, 1'b1, 64'd7, 64'd1, 1'b0, 1'b0);
      drv(0, 1'b1, 1'b1, 64'd3, 64'd5, 1'b0, 1'b1);
      idle(0, 8);
      // Back-to-back operations, third wraps with carry-out
      drv(0, 1'b1, 1'b1, 64'd2, 64'd3, 1'b0, 1'b0);
      drv(0, 1'b1, 1'b1, 64'd6, 64'd1, 1'b0, 1'b0);
      drv(0, 1'b1, 1'b1, 64'd13, 64'd4, 1'b1, 1'b0);
      idle(0, 8);
      // Hold for 3 cycles with two operations in flight; valid input ignored while held
      drv(0, 1'b1, 1'b1, 64'd9, 64'd4, 1'b0, 1'b0);
      drv(0, 1'b1, 1'b1, 64'd1, 64'd2, 1'b0, 1'b1);
      drv(0, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
      drv(0, 1'b1, 1'b0, 64'd15, 64'd15, 1'b1, 1'b0);
      drv(0, 1'b1, 1'b0, 64'd15, 64'd15, 1'b1, 1'b0);
      drv(0, 1'b1, 1'b0, 64'd15, 64'd15, 1'b1, 1'b0);
      idle(0, 10);

      // 16-bit wraparound to zero with carry-out
      drv(1, 1'b1, 1'b1, 64'hFFFF, 64'h0001, 1'b0, 1'b0);
      drv(1, 1'b1, 1'b1, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
      drv(1, 1'b1, 1'b1, 64'h8000, 64'h0001, 1'b0, 1'b1);
      idle(1, 10);

      // 5-bit random run with bubbles, holds, subtract, and a reset in mid-stream
      for (int n = 0; n < 10000; n++) begin
         if (n == 6000) rstn[2] = 1'b0;
         if (n == 6002) rstn[2] = 1'b1;
         drv(2, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
             longint'($urandom_range(0, 31)), longint'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(2, 12);
      idle(0, 2);
      idle(1, 2);

      for (int d = 0; d < 3; d++) chk("drained", d, 64'(sb[d].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
